seq_subtractor32: RTL and testbench
===================================

SEQ_SUBTRACTOR32 -- requirements
Module: seq_subtractor32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits processed per clock; WIDTH a multiple of DIGIT, DIGIT in {1,2,4,8}.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; operands sampled when accepted.
REQ-006 SHALL have port A  input  WIDTH  minuend.
REQ-007 SHALL have port B  input  WIDTH  subtrahend.
REQ-008 SHALL have port Bin  input  1  borrow-in.
REQ-009 SHALL have port busy  output  1  high while digits are being processed.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port D  output  WIDTH  difference A - B - Bin, modulo 2^WIDTH.
REQ-012 SHALL have port Bout  output  1  borrow-out, 1 when unsigned A < B + Bin.
REQ-013 SHALL have port overflow  output  1  two's-complement overflow of the subtraction.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 SHALL accept start only in IDLE or DONE, latching A, B and Bin, clearing the digit counter and entering RUN.
REQ-016 SHALL ignore start while in RUN; latched operands and progress are unaffected.
REQ-017 SHALL, in each RUN cycle, compute digit i (bits DIGIT*i+DIGIT-1 : DIGIT*i) as A + ~B + carry, where carry is the digit-(i-1) carry-out, or ~Bin for digit 0.
REQ-018 SHALL leave RUN for DONE after digit WIDTH/DIGIT-1, giving a latency of exactly WIDTH/DIGIT clocks from the accepting edge to done high.
REQ-019 SHALL assert done for exactly one cycle in DONE, then return to IDLE unless start is accepted in that cycle (back-to-back).
REQ-020 SHALL set Bout to the inverse of the final carry-out.
REQ-021 SHALL set overflow to the XOR of the MSB carry-in and the MSB carry-out.
REQ-022 SHALL hold D, Bout and overflow stable from done until the next accepted start.
REQ-023 SHALL hold busy high in RUN only.

Reset
REQ-024 SHALL, on rst_n low, immediately set state IDLE and counter 0, and drive busy, done, D, Bout and overflow to 0.
REQ-025 SHALL abort an operation when reset arrives mid-RUN; no done pulse results from it.
REQ-026 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with SEQ_SUBTRACTOR_ZERO_FLAG_EN defined, add output zero (1 bit), asserted with done and held like D, high when D == 0, reset 0.
REQ-028 SHALL, without SEQ_SUBTRACTOR_ZERO_FLAG_EN, have no zero port and no zero-detect logic.

Structure
REQ-029 SHALL place the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH/DIGIT constants in the shared package seq_sub_pkg.
REQ-030 SHALL instantiate one combinational sub-module sub_digit (DIGIT-bit slice: A, ~B, carry-in -> sum, carry-out, MSB carry-in) per RUN cycle.

Verification
REQ-031 SHALL cover: A=0x00000005, B=0x00000003, Bin=0 -> D=0x00000002, Bout=0, overflow=0; done exactly 8 clocks after the accepting edge.
REQ-032 SHALL cover: A=0x00000000, B=0x00000001, Bin=0 -> D=0xFFFFFFFF, Bout=1, overflow=0.
REQ-033 SHALL cover: A=0x80000000, B=0x00000001 -> D=0x7FFFFFFF, overflow=1, Bout=0; and A=0x7FFFFFFF, B=0xFFFFFFFF -> D=0x80000000, overflow=1, Bout=1.
REQ-034 SHALL cover: A=0x10, B=0x0F, Bin=1 -> D=0x00000000, Bout=0; with the macro defined, zero=1.
REQ-035 SHALL cover: start re-pulsed with new operands during RUN -> ignored, first result unchanged; start asserted in the DONE cycle -> second operation begins with no idle gap.
REQ-036 SHALL cover: rst_n pulsed low at RUN cycle 4 -> all outputs 0 immediately, no done pulse, and a fresh start after reset completes correctly.

Source files
------------

// File: rtl/seq_sub_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding
// and the default operand/digit widths.
package seq_sub_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_subtractor32_sub_digit.sv
// sub_digit: combinational DIGIT-bit slice of a borrow-style subtractor.
// The caller presents A and the already-inverted B; the slice adds them with
// a carry-in and reports the sum, the carry-out and the carry that entered the
// slice's top bit (used for two's-complement overflow detection).
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b_inv,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [DIGIT:0] total;

  assign total   = {1'b0, a} + {1'b0, b_inv} + {{DIGIT{1'b0}}, cin};
  assign sum     = total[DIGIT-1:0];
  assign cout    = total[DIGIT];
  // Sum bit = a ^ b ^ carry_in, so the carry into the top bit is recovered
  // from the top-bit operands and result.
  assign msb_cin = a[DIGIT-1] ^ b_inv[DIGIT-1] ^ sum[DIGIT-1];

endmodule

// File: rtl/seq_subtractor32.sv
// seq_subtractor32: digit-serial subtractor computing D = A - B - Bin.
// DIGIT bits are processed per clock, least-significant digit first, as
// A + ~B + carry with ~Bin seeding the first carry. A result takes exactly
// WIDTH/DIGIT clocks from the accepting edge to the done pulse.
// Optional feature: define SEQ_SUBTRACTOR_ZERO_FLAG_EN to add a 'zero'
// output that flags D == 0 alongside done.
module seq_subtractor32
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
  output logic             overflow,
  output logic             zero
`else
  output logic             overflow
`endif
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_next;

  logic             accept;
  logic             last_dig;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_msb_cin;

  // Start is only honoured outside RUN, so an operation in flight can never
  // be disturbed by a stray request.
  assign accept   = start && (state != RUN);
  assign last_dig = (cnt == LAST_DIG);

  // Operands are shifted right each RUN cycle, so the active digit always
  // sits in the low DIGIT bits.
  sub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a       (a_q[DIGIT-1:0]),
    .b_inv   (~b_q[DIGIT-1:0]),
    .cin     (carry_q),
    .sum     (dig_sum),
    .cout    (dig_cout),
    .msb_cin (dig_msb_cin)
  );

  // Partial result enters at the top and moves down; after NDIG shifts the
  // first digit has reached bit 0.
  always_comb begin
    diff_next = diff_q >> DIGIT;
    diff_next[WIDTH-1 -: DIGIT] = dig_sum;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_dig) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = accept ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, digit counter, running carry and partial difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      diff_q  <= '0;
    end else if (accept) begin
      cnt     <= '0;
      a_q     <= A;
      b_q     <= B;
      carry_q <= ~Bin;
    end else if (state == RUN) begin
      cnt     <= cnt + 1'b1;
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      carry_q <= dig_cout;
      diff_q  <= diff_next;
    end
  end

`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
  // Result registers update only on the final digit, so they stay frozen
  // from done until the next operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D        <= '0;
      Bout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if ((state == RUN) && last_dig) begin
      D        <= diff_next;
      Bout     <= ~dig_cout;
      overflow <= dig_msb_cin ^ dig_cout;
      zero     <= (diff_next == '0);
    end
  end
`else
  // Result registers update only on the final digit, so they stay frozen
  // from done until the next operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D        <= '0;
      Bout     <= 1'b0;
      overflow <= 1'b0;
    end else if ((state == RUN) && last_dig) begin
      D        <= diff_next;
      Bout     <= ~dig_cout;
      overflow <= dig_msb_cin ^ dig_cout;
    end
  end
`endif

endmodule

// File: tb/tb_seq_subtractor32.sv
// Scoreboard bench for seq_subtractor32: the driver pushes the expected
// result of every accepted operation, the monitor pops and compares on done.
module tb_seq_subtractor32;

  localparam int W    = 32;
  localparam int DG   = 4;
  localparam int NDIG = W / DG;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          Bin = 1'b0;
  logic          busy;
  logic          done;
  logic [W-1:0]  D;
  logic          Bout;
  logic          overflow;
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
  logic          zero;
`endif

  seq_subtractor32 #(.WIDTH(W), .DIGIT(DG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .busy     (busy),
    .done     (done),
    .D        (D),
    .Bout     (Bout),
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
    .overflow (overflow),
    .zero     (zero)
`else
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    logic         zf;
    int           done_cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain wide-integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bin, input int acc_cyc);
    exp_t   e;
    longint ua, ub, sa, sb, sd, ud;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ud = ua - ub - longint'(bin);
    sd = sa - sb - longint'(bin);
    e.d        = ud[W-1:0];
    e.bout     = (ua < ub + longint'(bin));
    e.ovf      = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    e.zf       = (e.d == '0);
    e.done_cyc = acc_cyc + NDIG;
    return e;
  endfunction

  // Must be called at a negedge where the DUT is not in RUN.
  task automatic issue_now(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    A = a; B = b; Bin = bin; start = 1'b1;
    sbq.push_back(model(a, b, bin, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
    issue_now(a, b, bin);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL wait_done actual=0 required=1");
    end
  endtask

  // Monitor: compares every done against the scoreboard and checks that
  // results are held while idle.
  logic [W-1:0] last_d;
  logic         last_bout, last_ovf, have_last, prev_done;
  initial begin
    exp_t e;
    have_last = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        have_last = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (done) begin
          check("done_pulse_width", {63'd0, prev_done}, 64'd0);
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done actual=done required=none");
          end else begin
            e = sbq.pop_front();
            check("D", {32'd0, D}, {32'd0, e.d});
            check("Bout", {63'd0, Bout}, {63'd0, e.bout});
            check("overflow", {63'd0, overflow}, {63'd0, e.ovf});
            check("latency", 64'(cyc), 64'(e.done_cyc));
`ifdef SEQ_SUBTRACTOR_ZERO_FLAG_EN
            check("zero", {63'd0, zero}, {63'd0, e.zf});
`endif
            last_d = e.d; last_bout = e.bout; last_ovf = e.ovf;
            have_last = 1'b1;
          end
        end else if (!busy && have_last) begin
          check("hold_D", {32'd0, D}, {32'd0, last_d});
          check("hold_flags", {62'd0, Bout, overflow}, {62'd0, last_bout, last_ovf});
        end
        prev_done = done;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_D", {32'd0, D}, 64'd0);
    check("rst_flags", {62'd0, Bout, overflow}, 64'd0);
    rst_n = 1'b1;

    // Directed corner cases
    issue(32'h0000_0005, 32'h0000_0003, 1'b0);
    issue(32'h0000_0000, 32'h0000_0001, 1'b0);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0);
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(32'h0000_0010, 32'h0000_000F, 1'b1);

    // Start re-pulsed with other operands during RUN is ignored
    issue(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
    A = 32'hFFFF_FFFF; B = 32'h0000_0000; Bin = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;

    // Start in the DONE cycle: back-to-back, no idle gap
    wait_done();
    issue_now(32'hCAFE_0000, 32'h0000_BEEF, 1'b1);
    wait_done();
    issue_now(32'h0000_0001, 32'h0000_0002, 1'b0);

    // Reset arriving in RUN cycle 4 aborts the operation
    issue(32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    void'(sbq.pop_back());
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_D", {32'd0, D}, 64'd0);
    check("abort_flags", {62'd0, Bout, overflow}, 64'd0);
    @(negedge clk);
    check("abort_hold_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    issue_now(32'h0000_0100, 32'h0000_0001, 1'b0);

    // Randomized operations with random gaps and back-to-back issues
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: rb = ra;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        wait_done();
        issue_now(ra, rb, 1'($urandom_range(0, 1)));
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        issue(ra, rb, 1'($urandom_range(0, 1)));
      end
    end

    // Drain the scoreboard, then observe a few idle cycles
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", 64'(sbq.size()), 64'd0);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
